pll_lock_supervisor: RTL
========================

# pll_lock_supervisor

Consumes the `locked` indication of the system PLL and drives that PLL's `rst` input. It runs in the 50 MHz `refclk` domain, ahead of the PLL. It pulses the PLL reset at power-up and on lock loss or lock timeout, and qualifies lock as stable before releasing the downstream system reset. It exposes relock and timeout counters for Nios software and SignalTap debug.

## Interface
Parameters:
- `RST_CYCLES`, 16: length of each PLL reset pulse, in refclk cycles (≥2).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: cycles of continuous lock required before reset release.
- `GLITCH_CYCLES`, 4: consecutive unlocked cycles tolerated in RUN (filter build only).
- `CNT_W`, 8: width of the status counters.

Ports:
- `refclk`  in  1  free-running reference clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pll_locked`  in  1  PLL lock flag; asynchronous to refclk.
- `pll_rst`  out  1  registered reset to the PLL `rst` input, active high.
- `rst_out`  out  1  registered system reset, active high; low only in RUN.
- `state`  out  2  current state: 0=PLL_RESET, 1=WAIT_LOCK, 2=STABLE, 3=RUN.
- `relock_count`  out  CNT_W  number of lock losses taken from RUN; saturating.
- `timeout_count`  out  CNT_W  number of WAIT_LOCK timeouts; saturating.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`. No other logic samples `pll_locked`.
- There is one shared down-counter or up-counter, `cnt`, sized with `$clog2` of the largest parameter. It clears on every state change.
- **PLL_RESET**
  - `pll_rst`=1 and `rst_out`=1.
  - After `RST_CYCLES` cycles, go to WAIT_LOCK.
  - `locked_s` is ignored in this state.
- **WAIT_LOCK**
  - `pll_rst`=0 and `rst_out`=1.
  - If `locked_s`=1, go to STABLE.
  - Otherwise, when `cnt`=`LOCK_TIMEOUT`-1, go to PLL_RESET and increment `timeout_count`.
  - If both happen on the same cycle, lock wins: go to STABLE with no count.
- **STABLE**
  - `pll_rst`=0 and `rst_out`=1.
  - If `locked_s`=0, go to WAIT_LOCK. The PLL is not reset and the timeout restarts.
  - When `cnt`=`STABLE_CYCLES`-1 with `locked_s`=1, go to RUN.
- **RUN**
  - `pll_rst`=0 and `rst_out`=0.
  - On lock loss (see Configuration), go to PLL_RESET and increment `relock_count`.
  - `rst_out` reasserts on the same edge as the state change.
- Both counters saturate at 2^CNT_W-1 and never wrap. Only `rst` clears them.
- Outputs `state`, `pll_rst` and `rst_out` are all registered, with no combinational path from inputs.

## Timing
- Reset values:
  - `state`=PLL_RESET, `pll_rst`=1, `rst_out`=1.
  - Both counters = 0.
  - `cnt` = 0 and the synchronizer flops = 0.
- After `rst` deasserts, `pll_rst` stays high for exactly `RST_CYCLES` rising edges.
- `rst_out` falls `STABLE_CYCLES`+3 edges after the first edge that samples `pll_locked` high. This assumes WAIT_LOCK is already active and lock holds throughout.
- Lock-loss response in RUN, counted from the first edge that samples `pll_locked` low:
  - Unfiltered build: `rst_out` rises 3 edges later.
  - Filtered build: `rst_out` rises `GLITCH_CYCLES`+2 edges later.
- Retry period with a PLL that never locks: `RST_CYCLES`+`LOCK_TIMEOUT` cycles.
- If `rst` asserts mid-operation, all outputs immediately (asynchronously) return to their reset values. Restart is clean, and no counter value survives.

## Configuration
- Macro: `PLL_SUP_GLITCH_FILTER_EN`.
- Defined:
  - RUN leaves only after `locked_s`=0 on `GLITCH_CYCLES` consecutive cycles.
  - Any cycle with `locked_s`=1 clears the filter count.
  - A drop shorter than the window has no effect: no reset and no count.
- Undefined:
  - A single cycle of `locked_s`=0 in RUN triggers PLL_RESET.
  - `GLITCH_CYCLES` is unused and no filter logic exists.

## Test plan
Bench parameters: `RST_CYCLES`=4, `LOCK_TIMEOUT`=100, `STABLE_CYCLES`=16, `GLITCH_CYCLES`=3, `CNT_W`=8.

- **Power-up, lock arrives**
  - Stimulus: release `rst`; `pll_locked` rises 10 cycles after WAIT_LOCK is entered.
  - Required: `pll_rst` high for 4 edges; `rst_out` falls 19 edges after `pll_locked` is first sampled high; `state`=3; both counters = 0.
- **PLL never locks**
  - Stimulus: hold `pll_locked`=0 for 520 cycles after the first WAIT_LOCK.
  - Required: `timeout_count`=5; `pll_rst` pulses with a period of 104 cycles; `rst_out` stays high.
- **Lock drops during STABLE**
  - Stimulus: `pll_locked` low for 1 cycle at STABLE `cnt`=8.
  - Required: return to WAIT_LOCK with no `pll_rst` pulse; when lock returns, the full 16 cycles are required again.
- **Lock loss in RUN**
  - Stimulus: `pll_locked` low for 5 cycles.
  - Required: `relock_count`=1; a 4-cycle `pll_rst` pulse; `rst_out` high until re-qualified.
- **Glitch filter, 2-cycle drop in RUN**
  - Filtered build: no state change and `relock_count`=0.
  - Unfiltered build: `relock_count`=1.
- **Saturation and mid-run reset**
  - Stimulus: force 260 lock losses, then assert `rst` mid-STABLE.
  - Required: `relock_count` holds at 255 before the reset; afterwards all outputs return to their reset values in the same cycle.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies lock, gates system reset.
// Ports: refclk/rst in; pll_locked in (async); pll_rst, rst_out, state,
// relock_count, timeout_count out. Optional RUN glitch filter: PLL_SUP_GLITCH_FILTER_EN.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int GLITCH_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             rst_out,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] relock_count,
  output logic [CNT_W-1:0] timeout_count
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT)
                        ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD = (STABLE_CYCLES > GLITCH_CYCLES)
                        ? STABLE_CYCLES : GLITCH_CYCLES;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
`ifdef PLL_SUP_GLITCH_FILTER_EN
  localparam logic [CW-1:0] GL_LAST  = CW'(GLITCH_CYCLES - 1);
`endif
  localparam logic [CNT_W-1:0] SAT = '1;

  state_t        st;
  logic [CW-1:0] cnt;
  logic          sync_q;
  logic          locked_s;

  assign state = st;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q        <= 1'b0;
      locked_s      <= 1'b0;
      st            <= PLL_RESET;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      rst_out       <= 1'b1;
      relock_count  <= '0;
      timeout_count <= '0;
    end else begin
      sync_q   <= pll_locked;
      locked_s <= sync_q;
      unique case (st)
        PLL_RESET: begin
          if (cnt == RST_LAST) begin
            st      <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // lock takes priority over a coincident timeout
          if (locked_s) begin
            st  <= STABLE;
            cnt <= '0;
          end else if (cnt == TO_LAST) begin
            st      <= PLL_RESET;
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (timeout_count != SAT)
              timeout_count <= timeout_count + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE: begin
          // a drop restarts the lock wait without resetting the PLL
          if (!locked_s) begin
            st  <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == STB_LAST) begin
            st      <= RUN;
            cnt     <= '0;
            rst_out <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
`ifdef PLL_SUP_GLITCH_FILTER_EN
          // cnt counts consecutive unlocked cycles
          if (locked_s) begin
            cnt <= '0;
          end else if (cnt == GL_LAST) begin
            st      <= PLL_RESET;
            cnt     <= '0;
            pll_rst <= 1'b1;
            rst_out <= 1'b1;
            if (relock_count != SAT)
              relock_count <= relock_count + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          if (!locked_s) begin
            st      <= PLL_RESET;
            cnt     <= '0;
            pll_rst <= 1'b1;
            rst_out <= 1'b1;
            if (relock_count != SAT)
              relock_count <= relock_count + 1'b1;
          end
`endif
        end
      endcase
    end
  end

endmodule
